// File: rtl/wb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// wb_regfile_pkg
//   Shared pipeline definitions for the MEM -> WB write-back path.
//   Provides the default data/address widths, the zero register/word
//   constants and the write-back bundle used by the MEM and WB stages.
// ---------------------------------------------------------------------------
package wb_regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ZERO_REG  = '0;
    localparam logic [DATA_W-1:0] ZERO_WORD = 32'h0;

    // One write-back transaction as it travels from MEM into WB.
    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_bundle_t;

endpackage

// File: rtl/wb_regfile_core.sv
// ---------------------------------------------------------------------------
// regfile_core
//   Architectural register storage: one synchronous write port and two
//   asynchronous read ports. r0 is hardwired to zero (writes ignored, reads
//   return zero). Contains no pipeline control.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset, clears every register
//   we/waddr/wdata write port
//   raddr1/rdata1  read port 1 (combinational)
//   raddr2/rdata2  read port 2 (combinational)
// ---------------------------------------------------------------------------
module regfile_core
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = wb_regfile_pkg::DATA_W,
    parameter int ADDR_W = wb_regfile_pkg::ADDR_W,
    parameter int NREGS  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != ZERO_REG)) begin
            regs[waddr] <= wdata;
        end
    end

    // r0 is forced to zero on read as well, so it never depends on storage.
    assign rdata1 = (raddr1 == ZERO_REG) ? ZERO_WORD : regs[raddr1];
    assign rdata2 = (raddr2 == ZERO_REG) ? ZERO_WORD : regs[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Write-back stage: MEM/WB pipeline latch (stall/flush), the 32x32 register
//   file it commits into, two ID-stage read ports and a retired-write counter.
//
//   Optional feature macro: WB_BYPASS_EN
//     defined   -> a read that matches the pending WB write returns wb_data_o
//                  in the same cycle.
//     undefined -> reads return register array contents only.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   write_reg_en_i/addr_i/data_i MEM-stage write request
//   stall, flush                 hold / squash the MEM/WB latch
//   re1, raddr1, rdata1          read port 1
//   re2, raddr2, rdata2          read port 2
//   wb_en_o, wb_addr_o, wb_data_o latched write (for forwarding logic)
//   retired_cnt_o                count of committed non-r0 writes
// ---------------------------------------------------------------------------
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = wb_regfile_pkg::DATA_W,
    parameter int ADDR_W = wb_regfile_pkg::ADDR_W,
    parameter int NREGS  = 2**ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_reg_en_i,
    input  logic [ADDR_W-1:0] write_reg_addr_i,
    input  logic [DATA_W-1:0] write_reg_data_i,
    input  logic              stall,
    input  logic              flush,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              wb_en_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [CNT_W-1:0]  retired_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    wb_bundle_t        wb_q;
    logic              committed;
    logic              commit;
    logic [CNT_W-1:0]  retired_cnt;
    logic [DATA_W-1:0] core_rdata1;
    logic [DATA_W-1:0] core_rdata2;

    assign commit = wb_q.en && (wb_q.addr != ZERO_REG);

    // The latch commits from its current contents on every edge, even while
    // stalled. 'committed' remembers that the held entry has already been
    // counted so a stalled write is retired exactly once; it clears whenever
    // the latch takes new contents (capture or flush bubble).
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q        <= '0;
            committed   <= 1'b0;
            retired_cnt <= '0;
        end else begin
            if (commit && !committed) begin
                retired_cnt <= retired_cnt + CNT_ONE;
            end
            if (flush) begin
                wb_q      <= '0;
                committed <= 1'b0;
            end else if (stall) begin
                committed <= committed | commit;
            end else begin
                wb_q.en   <= write_reg_en_i;
                wb_q.addr <= write_reg_addr_i;
                wb_q.data <= write_reg_data_i;
                committed <= 1'b0;
            end
        end
    end

    regfile_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .we     (commit),
        .waddr  (wb_q.addr),
        .wdata  (wb_q.data),
        .raddr1 (raddr1),
        .rdata1 (core_rdata1),
        .raddr2 (raddr2),
        .rdata2 (core_rdata2)
    );

    always_comb begin
        rdata1 = ZERO_WORD;
        rdata2 = ZERO_WORD;
        if (re1 && (raddr1 != ZERO_REG)) begin
            rdata1 = core_rdata1;
`ifdef WB_BYPASS_EN
            if (wb_q.en && (raddr1 == wb_q.addr)) begin
                rdata1 = wb_q.data;
            end
`endif
        end
        if (re2 && (raddr2 != ZERO_REG)) begin
            rdata2 = core_rdata2;
`ifdef WB_BYPASS_EN
            if (wb_q.en && (raddr2 == wb_q.addr)) begin
                rdata2 = wb_q.data;
            end
`endif
        end
    end

    assign wb_en_o       = wb_q.en;
    assign wb_addr_o     = wb_q.addr;
    assign wb_data_o     = wb_q.data;
    assign retired_cnt_o = retired_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//   Directed self-checking bench for wb_regfile. Expected values are
//   hand-computed constants; the bypass case follows WB_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        write_reg_en_i;
    logic [4:0]  write_reg_addr_i;
    logic [31:0] write_reg_data_i;
    logic        stall;
    logic        flush;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        wb_en_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic [31:0] retired_cnt_o;

    int checkCount;
    int errorCount;

`ifdef WB_BYPASS_EN
    localparam logic [31:0] BYPASS_EXP = 32'hA5A5_A5A5;
`else
    localparam logic [31:0] BYPASS_EXP = 32'h1111_1111;
`endif

    wb_regfile dut (
        .clk              (clk),
        .rst              (rst),
        .write_reg_en_i   (write_reg_en_i),
        .write_reg_addr_i (write_reg_addr_i),
        .write_reg_data_i (write_reg_data_i),
        .stall            (stall),
        .flush            (flush),
        .re1              (re1),
        .raddr1           (raddr1),
        .rdata1           (rdata1),
        .re2              (re2),
        .raddr2           (raddr2),
        .rdata2           (rdata2),
        .wb_en_o          (wb_en_o),
        .wb_addr_o        (wb_addr_o),
        .wb_data_o        (wb_data_o),
        .retired_cnt_o    (retired_cnt_o)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of MEM-stage / control inputs, then step past the edge.
    task automatic applyStimulus(input logic r, input logic en, input logic [4:0] addr,
                                 input logic [31:0] data, input logic st, input logic fl);
        rst              = r;
        write_reg_en_i   = en;
        write_reg_addr_i = addr;
        write_reg_data_i = data;
        stall            = st;
        flush            = fl;
        @(posedge clk);
        #1;
    endtask

    // Set up both read ports and let the combinational path settle.
    task automatic setReads(input logic e1, input logic [4:0] a1,
                            input logic e2, input logic [4:0] a2);
        re1    = e1;
        raddr1 = a1;
        re2    = e2;
        raddr2 = a2;
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        setReads(1'b0, 5'd0, 1'b0, 5'd0);

        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        // Preload r5, then reset and make sure everything is cleared.
        applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        setReads(1'b1, 5'd5, 1'b1, 5'd5);
        checkOutput("preload_r5", rdata1, 32'hDEAD_BEEF);
        checkOutput("preload_cnt", retired_cnt_o, 32'd1);

        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        checkOutput("reset_r5_p1", rdata1, 32'h0);
        checkOutput("reset_r5_p2", rdata2, 32'h0);
        checkOutput("reset_wb_en", {31'd0, wb_en_o}, 32'd0);
        checkOutput("reset_wb_addr", {27'd0, wb_addr_o}, 32'd0);
        checkOutput("reset_wb_data", wb_data_o, 32'h0);
        checkOutput("reset_cnt", retired_cnt_o, 32'd0);

        // Basic write: latched after edge N, visible in the array after N+1.
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h1234_5678, 1'b0, 1'b0);
        checkOutput("basic_wb_en", {31'd0, wb_en_o}, 32'd1);
        checkOutput("basic_wb_addr", {27'd0, wb_addr_o}, 32'd3);
        checkOutput("basic_wb_data", wb_data_o, 32'h1234_5678);
        checkOutput("basic_cnt_latched", retired_cnt_o, 32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        setReads(1'b1, 5'd3, 1'b0, 5'd3);
        checkOutput("basic_r3", rdata1, 32'h1234_5678);
        checkOutput("basic_re2_off", rdata2, 32'h0);
        checkOutput("basic_cnt", retired_cnt_o, 32'd1);

        // Writes to r0 are dropped and not counted.
        applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        setReads(1'b1, 5'd0, 1'b1, 5'd0);
        checkOutput("r0_p1", rdata1, 32'h0);
        checkOutput("r0_p2", rdata2, 32'h0);
        checkOutput("r0_cnt", retired_cnt_o, 32'd1);

        // Bypass: r7 holds an old value while a new write to r7 sits in WB.
        applyStimulus(1'b0, 1'b1, 5'd7, 32'h1111_1111, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 1'b0);
        setReads(1'b1, 5'd7, 1'b0, 5'd7);
        checkOutput("bypass_wb_addr", {27'd0, wb_addr_o}, 32'd7);
        checkOutput("bypass_r7", rdata1, BYPASS_EXP);
        checkOutput("bypass_re2_off", rdata2, 32'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        setReads(1'b1, 5'd7, 1'b1, 5'd7);
        checkOutput("bypass_r7_after", rdata1, 32'hA5A5_A5A5);
        checkOutput("bypass_r7_p2", rdata2, 32'hA5A5_A5A5);
        checkOutput("bypass_cnt", retired_cnt_o, 32'd3);

        // Stall: entry for r9 is held for three cycles, counted once.
        applyStimulus(1'b0, 1'b1, 5'd9, 32'h0000_0001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 5'd10, 32'h0000_0002, 1'b1, 1'b0);
        end
        setReads(1'b1, 5'd9, 1'b1, 5'd10);
        checkOutput("stall_wb_en", {31'd0, wb_en_o}, 32'd1);
        checkOutput("stall_wb_addr", {27'd0, wb_addr_o}, 32'd9);
        checkOutput("stall_wb_data", wb_data_o, 32'h0000_0001);
        checkOutput("stall_cnt", retired_cnt_o, 32'd4);
        checkOutput("stall_r9", rdata1, 32'h0000_0001);
        checkOutput("stall_r10", rdata2, 32'h0);

        // Flush beats stall.
        applyStimulus(1'b0, 1'b1, 5'd10, 32'h0000_0002, 1'b1, 1'b1);
        checkOutput("flush_wb_en", {31'd0, wb_en_o}, 32'd0);
        checkOutput("flush_wb_addr", {27'd0, wb_addr_o}, 32'd0);
        checkOutput("flush_cnt", retired_cnt_o, 32'd4);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        checkOutput("flush_r10", rdata2, 32'h0);

        // Reset while a write to r4 is in the latch: it must not commit.
        applyStimulus(1'b0, 1'b1, 5'd4, 32'h0000_0007, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        setReads(1'b1, 5'd4, 1'b1, 5'd9);
        checkOutput("midrst_r4", rdata1, 32'h0);
        checkOutput("midrst_r9", rdata2, 32'h0);
        checkOutput("midrst_cnt", retired_cnt_o, 32'd0);
        checkOutput("midrst_wb_en", {31'd0, wb_en_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM-stage write-back interface.
- Contains the MEM/WB pipeline register with stall and flush, plus the 32x32 general-purpose register file that the write-back commits into.
- Provides two read ports to the ID stage, with optional same-cycle write-to-read bypass.
- Provides a retired-write counter for debug and performance.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- NREGS, 32, number of architectural registers (2**ADDR_W).
- CNT_W, 32, width of retired-write counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- write_reg_en_i  in  1  MEM-stage write enable.
- write_reg_addr_i  in  ADDR_W  MEM-stage destination register.
- write_reg_data_i  in  DATA_W  MEM-stage write data.
- stall  in  1  hold the MEM/WB register.
- flush  in  1  squash the MEM/WB register contents.
- re1  in  1  read port 1 enable.
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data.
- re2  in  1  read port 2 enable.
- raddr2  in  ADDR_W  read port 2 address.
- rdata2  out  DATA_W  read port 2 data.
- wb_en_o  out  1  registered write enable (WB stage, visible to forwarding logic).
- wb_addr_o  out  ADDR_W  registered write address.
- wb_data_o  out  DATA_W  registered write data.
- retired_cnt_o  out  CNT_W  count of committed non-r0 writes.

Behaviour:
- Reset (rst=1 at a clock edge):
  - wb_en_o=0, wb_addr_o=0, wb_data_o=0, retired_cnt_o=0.
  - All registers r0..r31 cleared to 0.
  - rst has priority over stall and flush.
  - Reset mid-operation discards any in-flight write in the MEM/WB latch; that write is not committed on the reset edge.
- MEM/WB latch, per clock edge when rst=0:
  - flush=1: en/addr/data <- 0 (bubble). flush has priority over stall.
  - else stall=1: hold current contents.
  - else: capture write_reg_*_i.
- Commit, same edge as the latch update:
  - When wb_en_o=1 and wb_addr_o!=0, reg[wb_addr_o] <= wb_data_o and retired_cnt_o increments by 1.
  - Commit proceeds regardless of stall: a held write re-commits the same value each cycle, which is harmless.
  - retired_cnt_o increments only on the first commit of a held entry. A per-entry "committed" flag is cleared whenever new contents are captured.
  - retired_cnt_o wraps modulo 2**CNT_W.
  - Total latency: MEM-stage inputs become architecturally visible 2 edges after presentation, i.e. latched on edge N and written into the array on edge N+1.
- Writes to r0 are ignored; r0 always reads 0.
- Reads (combinational from array and WB latch), per port:
  - re=0 -> rdata=0.
  - addr=0 -> 0.
  - bypass hit (see Optional Feature) -> wb_data_o.
  - else reg[addr].
- Both ports are independent and may address the same register.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: a read with re=1, raddr==wb_addr_o, wb_en_o=1, raddr!=0 returns wb_data_o in the same cycle, so no 3-cycle RAW hazard reaches ID.
- Undefined: reads return array contents only. The hazard unit must stall one extra cycle after a write before a dependent read.

Decomposition:
- Shared package (pipeline pkg):
  - DATA_W, ADDR_W.
  - ZERO_REG=0, ZERO_WORD=32'h0.
  - Write-back bundle typedef {en, addr[4:0], data[31:0]}, reused by the mem and wb stages.
- One natural sub-module: regfile_core.
  - Storage array with one sync write port and two async read ports, r0 hardwired.
  - Holds no pipeline control.

Test Plan:
- Reset: preload r5=32'hDEAD_BEEF, assert rst one cycle -> all reads 0, wb_en_o=0, retired_cnt_o=0.
- Basic write: en=1, addr=3, data=32'h1234_5678 at edge N -> wb_* updated after N; read r3 returns the value after N+1; retired_cnt_o=1.
- r0 protection: en=1, addr=0, data=32'hFFFF_FFFF -> rdata for addr 0 stays 0; retired_cnt_o unchanged.
- Bypass: write addr=7, data=32'hA5A5_A5A5; in the cycle wb_addr_o=7, read raddr1=7:
  - WB_BYPASS_EN defined -> rdata1=32'hA5A5_A5A5.
  - Undefined -> old r7 value.
- Stall/flush:
  - Latch addr=9, data=1; assert stall 3 cycles with new inputs -> wb_* hold, retired_cnt_o +1 only.
  - Assert stall+flush together -> wb_en_o=0 next cycle.
- Reset mid-op: latch write addr=4, data=7; assert rst the next edge -> r4 reads 0, retired_cnt_o=0.
